// File: rtl/obstacle_field.sv
// obstacle_field: N rectangular obstacles stepped one per clock after each
// accepted animation strobe, with per-axis wrap/bounce rules, per-obstacle
// collision flags against a player box and packed edge outputs.
module obstacle_field #(
  parameter int N         = 4,
  parameter int H_WIDTH   = 20,
  parameter int H_HEIGHT  = 20,
  parameter int IX        = 320,
  parameter int IY        = 240,
  parameter int X_SPACING = 160,
  parameter int IX_DIR    = 1,
  parameter int IY_DIR    = 1,
  parameter int X_MODE    = 0,
  parameter int Y_MODE    = 1,
  parameter int D_WIDTH   = 640,
  parameter int D_HEIGHT  = 480
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ani_stb,
  input  logic            i_animate,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [3:0]      i_ld_idx,
  input  logic [11:0]     i_ld_x,
  input  logic [11:0]     i_ld_y,
  input  logic            i_ld_xdir,
  input  logic            i_ld_ydir,
  input  logic [3:0]      i_ld_speed,
  input  logic [11:0]     i_px1,
  input  logic [11:0]     i_px2,
  input  logic [11:0]     i_py1,
  input  logic [11:0]     i_py2,
  output logic [N*12-1:0] o_x1,
  output logic [N*12-1:0] o_x2,
  output logic [N*12-1:0] o_y1,
  output logic [N*12-1:0] o_y2,
  output logic [N-1:0]    o_hit,
  output logic            o_hit_any,
  output logic            o_busy,
  output logic            o_frame_done
);

  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 1 << IW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic signed [13:0] XD = 14'(D_WIDTH);
  localparam logic signed [13:0] XH = 14'(H_WIDTH);
  localparam logic signed [13:0] YD = 14'(D_HEIGHT);
  localparam logic signed [13:0] YH = 14'(H_HEIGHT);
  localparam logic signed [11:0] HW12 = 12'(H_WIDTH);
  localparam logic signed [11:0] HH12 = 12'(H_HEIGHT);
  localparam logic XM = (X_MODE != 0);
  localparam logic YM = (Y_MODE != 0);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic              pending;
  logic              frame_done;
  logic [N-1:0]      hit;
  logic signed [11:0] pos_x [DEPTH];
  logic signed [11:0] pos_y [DEPTH];
  logic              dir_x [DEPTH];
  logic              dir_y [DEPTH];
  logic [3:0]        speed [DEPTH];

  logic              go;
  logic              ld_in_range;
  logic [IW-1:0]     ld_sel;
  logic [12:0]       step_x, step_y;
  logic signed [11:0] nx, ny;
  logic              ndx, ndy, nhit;
  logic signed [11:0] px1, px2, py1, py2;

  // One axis step; returns {new_dir, new_pos}. Done at 14 bits so the
  // boundary compares cannot be confused by 12-bit overflow near the edges.
  function automatic logic [12:0] step_axis(
    input logic signed [11:0] pos,
    input logic               dir,
    input logic [3:0]         spd,
    input logic               bounce,
    input logic signed [13:0] d,
    input logic signed [13:0] h
  );
    logic signed [13:0] p, s, nxt, np;
    logic               nd;
    p   = {{2{pos[11]}}, pos};
    s   = {10'b0, spd};
    nxt = dir ? (p + s) : (p - s);
    np  = nxt;
    nd  = dir;
    if (spd == 4'd0) begin
      np = p;
    end else if (!bounce) begin
      if (dir && (nxt > d + h))       np = -h;
      else if (!dir && (nxt < -h))    np = d + h;
    end else begin
      if (dir && (nxt >= d - h - 14'sd1)) begin
        np = d - h - 14'sd1;
        nd = 1'b0;
      end else if (!dir && (nxt <= h)) begin
        np = h;
        nd = 1'b1;
      end
    end
    return {nd, np[11:0]};
  endfunction

  assign go          = i_ani_stb && i_animate;
  assign ld_in_range = (32'(i_ld_idx) < N);
  assign ld_sel      = i_ld_idx[IW-1:0];
  assign px1 = $signed(i_px1);
  assign px2 = $signed(i_px2);
  assign py1 = $signed(i_py1);
  assign py2 = $signed(i_py2);

  // Next position, direction and collision of the obstacle being swept.
  always_comb begin
    step_x = step_axis(pos_x[idx], dir_x[idx], speed[idx], XM, XD, XH);
    step_y = step_axis(pos_y[idx], dir_y[idx], speed[idx], YM, YD, YH);
    nx   = $signed(step_x[11:0]);
    ny   = $signed(step_y[11:0]);
    ndx  = step_x[12];
    ndy  = step_y[12];
    nhit = ((nx - HW12) <= px2) && ((nx + HW12) >= px1) &&
           ((ny - HH12) <= py2) && ((ny + HH12) >= py1);
  end

  // Sweep FSM, load port and obstacle state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pos_x[i] <= 12'(IX + int'(i) * X_SPACING);
        pos_y[i] <= 12'(IY);
        dir_x[i] <= (IX_DIR != 0);
        dir_y[i] <= (IY_DIR != 0);
        speed[i] <= 4'd1;
      end
      hit        <= '0;
      state      <= IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_ld_valid && ld_in_range) begin
            pos_x[ld_sel] <= $signed(i_ld_x);
            pos_y[ld_sel] <= $signed(i_ld_y);
            dir_x[ld_sel] <= i_ld_xdir;
            dir_y[ld_sel] <= i_ld_ydir;
            speed[ld_sel] <= i_ld_speed;
            hit[ld_sel]   <= 1'b0;
          end
          // A strobe colliding with a load is deferred by one cycle.
          if (i_ld_valid && go) begin
            pending <= 1'b1;
          end else if (go || pending) begin
            state   <= UPDATE;
            idx     <= '0;
            pending <= 1'b0;
          end
        end
        UPDATE: begin
          pos_x[idx] <= nx;
          pos_y[idx] <= ny;
          dir_x[idx] <= ndx;
          dir_y[idx] <= ndy;
          hit[idx]   <= nhit;
          if (idx == LAST) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Packed edge outputs derived from the stored centres.
  always_comb begin
    o_x1 = '0;
    o_x2 = '0;
    o_y1 = '0;
    o_y2 = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_x1[12*i +: 12] = pos_x[i] - HW12;
      o_x2[12*i +: 12] = pos_x[i] + HW12;
      o_y1[12*i +: 12] = pos_y[i] - HH12;
      o_y2[12*i +: 12] = pos_y[i] + HH12;
    end
  end

  assign o_ld_ready   = (state == IDLE);
  assign o_busy       = (state == UPDATE);
  assign o_hit        = hit;
  assign o_hit_any    = |hit;
  assign o_frame_done = frame_done;

endmodule

// File: doc/obstacle_field.md
# obstacle_field

Parametrised multi-obstacle motion engine for the VGA game pipeline. Holds N independent rectangular obstacles, each with its own centre, direction and speed. On every accepted animation strobe it steps all N through a sequential one-obstacle-per-clock update, applying wrap or bounce rules per axis. It flags per-obstacle collisions against a player box and feeds packed edge coordinates to the pixel renderer.

## Interface
- N, 4: number of obstacles (1-16)
- H_WIDTH, 20: half obstacle width
- H_HEIGHT, 20: half obstacle height
- IX, 320: reset centre x of obstacle 0
- IY, 240: reset centre y of all obstacles
- X_SPACING, 160: reset x offset between consecutive obstacles
- IX_DIR, 1: reset x direction (1 right, 0 left)
- IY_DIR, 1: reset y direction (1 down, 0 up)
- X_MODE, 0: x-axis edge rule (0 wrap, 1 bounce)
- Y_MODE, 1: y-axis edge rule (0 wrap, 1 bounce)
- D_WIDTH, 640: display width
- D_HEIGHT, 480: display height
- i_clk  in  1  base clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_ani_stb  in  1  animation strobe, one-cycle pulse
- i_animate  in  1  enables stepping when high
- i_ld_valid  in  1  load request
- o_ld_ready  out  1  load accepted when high with i_ld_valid
- i_ld_idx  in  4  obstacle index to load
- i_ld_x, i_ld_y  in  12 each  signed centre to load
- i_ld_xdir, i_ld_ydir  in  1 each  directions to load
- i_ld_speed  in  4  pixels per step to load (0 = stationary)
- i_px1, i_px2, i_py1, i_py2  in  12 each  player box edges, signed, inclusive
- o_x1, o_x2, o_y1, o_y2  out  N*12 each  packed obstacle edges; obstacle i at bits [12i+11:12i]
- o_hit  out  N  per-obstacle overlap with player box
- o_hit_any  out  1  OR of o_hit
- o_busy  out  1  update sweep in progress
- o_frame_done  out  1  one-cycle pulse at end of sweep

## Operation
- Coordinates are 12-bit two's-complement signed. All comparisons are signed. Edges are combinational from the centres: x1=x-H_WIDTH, x2=x+H_WIDTH, y1=y-H_HEIGHT, y2=y+H_HEIGHT.
- Reset values:
  - Obstacle i: x=IX+i*X_SPACING (12-bit truncated), y=IY, dirs IX_DIR/IY_DIR, speed 1.
  - o_hit=0, state IDLE, pending=0, o_frame_done=0.
- FSM states:
  - IDLE: start a sweep when (i_ani_stb && i_animate) or pending. Go to UPDATE with idx=0 and clear pending.
  - UPDATE: one cycle per obstacle idx. Write the new x, y, dirs and o_hit[idx]. After idx=N-1, go to IDLE and pulse o_frame_done.
- Step rule per axis, with s=speed, nxt = pos±s:
  - Wrap, moving positive: if nxt > D+H then pos=-H, else pos=nxt.
  - Wrap, moving negative: if nxt < -H then pos=D+H, else pos=nxt.
  - Bounce, moving positive: if nxt >= D-H-1 then pos=D-H-1 and dir=0, else pos=nxt.
  - Bounce, moving negative: if nxt <= H then pos=H and dir=1, else pos=nxt.
  - D/H are D_WIDTH/H_WIDTH for the x axis and D_HEIGHT/H_HEIGHT for the y axis.
  - Speed 0: position and dir unchanged.
- Collision: o_hit[idx] is set from the new edges: x1<=i_px2 && x2>=i_px1 && y1<=i_py2 && y2>=i_py1. Non-updated bits hold.
- Load:
  - o_ld_ready = (state==IDLE).
  - Accepted load overwrites x, y, dirs and speed of i_ld_idx and clears o_hit[i_ld_idx].
  - i_ld_idx >= N: accepted, no effect.
- Strobe in the same cycle as an accepted load: the load wins, pending is set, and the sweep starts the next cycle.
- Strobe while in UPDATE: ignored. No queuing.
- i_animate low: strobes are ignored. Loads still work.

## Timing
- Sweep latency: N cycles after the start cycle. o_busy is high for exactly N cycles. o_frame_done is asserted in the cycle after the last write.
- Edge outputs update on the clock edge the obstacle is written. The renderer must sample only while o_busy=0.
- i_rst_n low asynchronously forces all reset values regardless of state, including mid-sweep. Release is synchronised externally.

## Test plan
- Reset defaults (N=4): after i_rst_n deasserts, o_x1 fields = 300,460,620,780(x centres 320,480,640,800), o_busy=0, o_hit=0.
- Single sweep: one strobe with i_animate=1 -> o_busy high 4 cycles, obstacle 0 x=321, y=241, o_frame_done pulse once.
- X wrap: load idx0 x=660, xdir=1, speed 1, one strobe -> x=-20 (o_x1=-40 as 12-bit 0xFD8).
- Y bounce: load idx1 y=457, ydir=1, speed 4 -> y=459, ydir=0. Next strobe -> y=455.
- Collision and coincidence: player box 300..340/220..260, obstacle 0 at (320,240) -> o_hit[0]=1, o_hit_any=1. Load plus strobe in the same cycle -> load applied, sweep begins next cycle.
- Mid-sweep reset: assert i_rst_n=0 during UPDATE idx=2 -> all outputs return to reset values immediately, o_frame_done never pulses.
